parity_unit: RTL and testbench

- Parametrised parity engine for the UART, successor to the fixed 8-bit even/odd TX parity calculator.
- TX side: latches parallel data and produces the parity bit for a runtime-selected data length and parity mode (none/even/odd/mark/space).
- RX side: accumulates serial data bits into a running parity, checks the received parity bit, and keeps error statistics.
- Sits between the UART TX/RX FSMs and the configuration registers; one instance serves both directions.

---
 rtl/parity_unit.sv | 180 ++++++++++++++++++
 tb/tb_parity_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_unit.sv
// Shared TX/RX parity engine for the UART: TX parity generation, RX parity check,
// and parity-error statistics. Frame length and parity mode are chosen at runtime.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no RX frame in progress, strobes ignored
//   ACCUM    | folding sampled data bits into the running parity
//   WAIT_PAR | all data bits seen, waiting for the parity bit strobe
module parity_unit #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int ERR_CNT_WIDTH  = 8,
    localparam int LEN_W = $clog2(MAX_DATA_WIDTH + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2:0]                PAR_MODE,
    input  logic [LEN_W-1:0]          DATA_LEN,
    input  logic [MAX_DATA_WIDTH-1:0] P_DATA,
    input  logic                      Data_Valid,
    input  logic                      BUSY,
    output logic                      TX_Par_Bit,
    output logic                      TX_Par_En,
    output logic                      TX_Par_Vld,
    input  logic                      RX_Start,
    input  logic                      RX_Bit_Strb,
    input  logic                      RX_Par_Strb,
    input  logic                      RX_Bit,
    output logic                      RX_Done,
    output logic                      Par_Err,
    output logic                      Par_Err_Sticky,
    output logic [ERR_CNT_WIDTH-1:0]  Err_Cnt,
    input  logic                      Err_Clr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_PAR = 2'd2
    } rx_state_t;

    // Zero or oversized lengths fall back to the widest frame.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0 || int'(len) > MAX_DATA_WIDTH)
            return LEN_W'(MAX_DATA_WIDTH);
        return len;
    endfunction

    function automatic logic mode_en(input logic [2:0] mode);
        return (mode >= 3'b001) && (mode <= 3'b100);
    endfunction

    function automatic logic mode_bit(input logic [2:0] mode, input logic xor_in);
        case (mode)
            3'b001:  return xor_in;
            3'b010:  return ~xor_in;
            3'b011:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [MAX_DATA_WIDTH-1:0] tx_data_q;
    logic [2:0]                tx_mode_q;
    logic [LEN_W-1:0]          tx_len_q;
    logic                      tx_ld_q;
    logic                      tx_xor;
    logic                      tx_load;

    assign tx_load = Data_Valid && !BUSY;

    always_comb begin
        tx_xor = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < int'(tx_len_q))
                tx_xor = tx_xor ^ tx_data_q[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_data_q  <= '0;
            tx_mode_q  <= '0;
            tx_len_q   <= '0;
            tx_ld_q    <= 1'b0;
            TX_Par_Bit <= 1'b0;
            TX_Par_En  <= 1'b0;
            TX_Par_Vld <= 1'b0;
        end else begin
            tx_ld_q    <= tx_load;
            TX_Par_Vld <= tx_ld_q;
            if (tx_load) begin
                tx_data_q <= P_DATA;
                tx_mode_q <= PAR_MODE;
                tx_len_q  <= clamp_len(DATA_LEN);
            end
            if (tx_ld_q) begin
                TX_Par_Bit <= mode_bit(tx_mode_q, tx_xor);
                TX_Par_En  <= mode_en(tx_mode_q);
            end
        end
    end

    rx_state_t        rx_state;
    logic [2:0]       rx_mode_q;
    logic [LEN_W-1:0] rx_len_q;
    logic [LEN_W-1:0] rx_cnt_q;
    logic [LEN_W-1:0] rx_cnt_nxt;
    logic             rx_acc_q;
    logic             chk_pend_q;
    logic             chk_err_q;

    assign rx_cnt_nxt = rx_cnt_q + LEN_W'(1);

    // The parity-bit verdict is held one cycle in chk_pend_q/chk_err_q before it
    // is presented, so the FSM itself can already return to IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_state   <= IDLE;
            rx_mode_q  <= '0;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_acc_q   <= 1'b0;
            chk_pend_q <= 1'b0;
            chk_err_q  <= 1'b0;
            RX_Done    <= 1'b0;
            Par_Err    <= 1'b0;
        end else begin
            RX_Done    <= chk_pend_q;
            Par_Err    <= chk_pend_q && chk_err_q;
            chk_pend_q <= 1'b0;
            chk_err_q  <= 1'b0;
            if (RX_Start) begin
                rx_mode_q <= PAR_MODE;
                rx_len_q  <= clamp_len(DATA_LEN);
                rx_cnt_q  <= '0;
                rx_acc_q  <= 1'b0;
                rx_state  <= ACCUM;
            end else begin
                case (rx_state)
                    ACCUM: begin
                        if (RX_Bit_Strb) begin
                            rx_acc_q <= rx_acc_q ^ RX_Bit;
                            rx_cnt_q <= rx_cnt_nxt;
                            if (rx_cnt_nxt == rx_len_q) begin
                                if (mode_en(rx_mode_q)) begin
                                    rx_state <= WAIT_PAR;
                                end else begin
                                    RX_Done  <= 1'b1;
                                    rx_state <= IDLE;
                                end
                            end
                        end
                    end
                    WAIT_PAR: begin
                        if (RX_Par_Strb) begin
                            chk_pend_q <= 1'b1;
                            chk_err_q  <= RX_Bit != mode_bit(rx_mode_q, rx_acc_q);
                            rx_state   <= IDLE;
                        end
                    end
                    default: rx_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Par_Err_Sticky <= 1'b0;
            Err_Cnt        <= '0;
        end else if (Err_Clr) begin
            Par_Err_Sticky <= 1'b0;
            Err_Cnt        <= '0;
        end else if (Par_Err) begin
            Par_Err_Sticky <= 1'b1;
            if (Err_Cnt != '1)
                Err_Cnt <= Err_Cnt + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_parity_unit.sv
// Directed bench for parity_unit: TX parity per mode/length, RX frame checking,
// restart behaviour, error counter saturation/clear and asynchronous reset.
module tb_parity_unit;
    localparam int MAXW = 8;
    localparam int ECW  = 2;
    localparam int LW   = $clog2(MAXW + 1);

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [2:0]      PAR_MODE = '0;
    logic [LW-1:0]   DATA_LEN = '0;
    logic [MAXW-1:0] P_DATA = '0;
    logic            Data_Valid = 1'b0;
    logic            BUSY = 1'b0;
    logic            TX_Par_Bit, TX_Par_En, TX_Par_Vld;
    logic            RX_Start = 1'b0;
    logic            RX_Bit_Strb = 1'b0;
    logic            RX_Par_Strb = 1'b0;
    logic            RX_Bit = 1'b0;
    logic            RX_Done, Par_Err, Par_Err_Sticky;
    logic [ECW-1:0]  Err_Cnt;
    logic            Err_Clr = 1'b0;

    int checks = 0;
    int errors = 0;

    parity_unit #(.MAX_DATA_WIDTH(MAXW), .ERR_CNT_WIDTH(ECW)) dut (
        .CLK(CLK), .RST(RST), .PAR_MODE(PAR_MODE), .DATA_LEN(DATA_LEN),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .BUSY(BUSY),
        .TX_Par_Bit(TX_Par_Bit), .TX_Par_En(TX_Par_En), .TX_Par_Vld(TX_Par_Vld),
        .RX_Start(RX_Start), .RX_Bit_Strb(RX_Bit_Strb), .RX_Par_Strb(RX_Par_Strb),
        .RX_Bit(RX_Bit), .RX_Done(RX_Done), .Par_Err(Par_Err),
        .Par_Err_Sticky(Par_Err_Sticky), .Err_Cnt(Err_Cnt), .Err_Clr(Err_Clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; one call spans one rising edge.
    task automatic tx_load(input logic [MAXW-1:0] d, input logic [2:0] m, input logic [LW-1:0] l);
        P_DATA = d; PAR_MODE = m; DATA_LEN = l; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic rx_start(input logic [2:0] m, input logic [LW-1:0] l);
        PAR_MODE = m; DATA_LEN = l; RX_Start = 1'b1;
        @(negedge CLK);
        RX_Start = 1'b0;
    endtask

    task automatic rx_bit(input logic b);
        RX_Bit = b; RX_Bit_Strb = 1'b1;
        @(negedge CLK);
        RX_Bit_Strb = 1'b0;
    endtask

    task automatic rx_par(input logic b);
        RX_Bit = b; RX_Par_Strb = 1'b1;
        @(negedge CLK);
        RX_Par_Strb = 1'b0;
    endtask

    task automatic err_frame();
        rx_start(3'b011, LW'(5));
        for (int i = 0; i < 5; i++) rx_bit(1'b0);
        rx_par(1'b0);
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_tx_bit", TX_Par_Bit, 0);
        chk("rst_tx_en", TX_Par_En, 0);
        chk("rst_tx_vld", TX_Par_Vld, 0);
        chk("rst_rx_done", RX_Done, 0);
        chk("rst_par_err", Par_Err, 0);
        chk("rst_sticky", Par_Err_Sticky, 0);
        chk("rst_cnt", Err_Cnt, 0);
        RST = 1'b1;
        @(negedge CLK);

        // TX even, len 8, 0xA7 has five ones
        tx_load(8'hA7, 3'b001, LW'(8));
        chk("tx_even_vld_early", TX_Par_Vld, 0);
        @(negedge CLK);
        chk("tx_even_vld", TX_Par_Vld, 1);
        chk("tx_even_bit", TX_Par_Bit, 1);
        chk("tx_even_en", TX_Par_En, 1);
        @(negedge CLK);
        chk("tx_even_vld_once", TX_Par_Vld, 0);
        chk("tx_even_hold", TX_Par_Bit, 1);

        tx_load(8'hA7, 3'b010, LW'(8));
        @(negedge CLK);
        chk("tx_odd_bit", TX_Par_Bit, 0);
        chk("tx_odd_vld", TX_Par_Vld, 1);

        // len 5 masks the upper ones of 0xE1
        tx_load(8'hE1, 3'b001, LW'(5));
        @(negedge CLK);
        chk("tx_len5_bit", TX_Par_Bit, 1);
        tx_load(8'h00, 3'b011, LW'(5));
        @(negedge CLK);
        chk("tx_mark_bit", TX_Par_Bit, 1);
        chk("tx_mark_en", TX_Par_En, 1);
        tx_load(8'hFF, 3'b100, LW'(7));
        @(negedge CLK);
        chk("tx_space_bit", TX_Par_Bit, 0);
        tx_load(8'h01, 3'b011, LW'(8));
        @(negedge CLK);
        tx_load(8'h01, 3'b000, LW'(8));
        @(negedge CLK);
        chk("tx_none_bit", TX_Par_Bit, 0);
        chk("tx_none_en", TX_Par_En, 0);

        // load while busy is dropped
        BUSY = 1'b1;
        tx_load(8'h00, 3'b011, LW'(8));
        BUSY = 1'b0;
        chk("tx_busy_vld0", TX_Par_Vld, 0);
        @(negedge CLK);
        chk("tx_busy_vld1", TX_Par_Vld, 0);
        chk("tx_busy_en", TX_Par_En, 0);

        // length 0 and 12 clamp to 8: 0x80 then has one set bit
        tx_load(8'h80, 3'b001, LW'(0));
        @(negedge CLK);
        chk("tx_len0_bit", TX_Par_Bit, 1);
        tx_load(8'h80, 3'b010, LW'(12));
        @(negedge CLK);
        chk("tx_len12_bit", TX_Par_Bit, 0);

        // back-to-back loads
        tx_load(8'hA7, 3'b001, LW'(8));
        tx_load(8'hA7, 3'b010, LW'(8));
        chk("tx_b2b_vld1", TX_Par_Vld, 1);
        chk("tx_b2b_bit1", TX_Par_Bit, 1);
        @(negedge CLK);
        chk("tx_b2b_vld2", TX_Par_Vld, 1);
        chk("tx_b2b_bit2", TX_Par_Bit, 0);
        @(negedge CLK);
        chk("tx_b2b_end", TX_Par_Vld, 0);

        // RX odd, len 7, three ones -> expected parity 0
        rx_start(3'b010, LW'(7));
        rx_bit(1); rx_bit(0); rx_bit(1); rx_bit(1); rx_bit(0); rx_bit(0); rx_bit(0);
        chk("rx_odd_no_early_done", RX_Done, 0);
        rx_par(1'b0);
        chk("rx_odd_done_latency", RX_Done, 0);
        @(negedge CLK);
        chk("rx_odd_done", RX_Done, 1);
        chk("rx_odd_err", Par_Err, 0);
        @(negedge CLK);
        chk("rx_odd_done_once", RX_Done, 0);

        rx_start(3'b010, LW'(7));
        rx_bit(1); rx_bit(0); rx_bit(1); rx_bit(1); rx_bit(0); rx_bit(0); rx_bit(0);
        rx_par(1'b1);
        @(negedge CLK);
        chk("rx_bad_done", RX_Done, 1);
        chk("rx_bad_err", Par_Err, 1);
        @(negedge CLK);
        chk("rx_bad_err_once", Par_Err, 0);
        chk("rx_bad_sticky", Par_Err_Sticky, 1);
        chk("rx_bad_cnt", Err_Cnt, 1);

        // mode none, len 6: done straight out of ACCUM
        rx_start(3'b000, LW'(6));
        for (int i = 0; i < 5; i++) rx_bit(1'b1);
        chk("rx_none_early", RX_Done, 0);
        rx_bit(1'b0);
        chk("rx_none_done", RX_Done, 1);
        chk("rx_none_err", Par_Err, 0);
        rx_par(1'b1);
        chk("rx_none_par_ignored", RX_Done, 0);
        @(negedge CLK);
        chk("rx_none_no_late_done", RX_Done, 0);

        // restart after three bits; new frame has one set bit
        rx_start(3'b001, LW'(4));
        rx_bit(1); rx_bit(1); rx_bit(1);
        rx_start(3'b001, LW'(4));
        rx_bit(1); rx_bit(0); rx_bit(0); rx_bit(0);
        rx_par(1'b1);
        @(negedge CLK);
        chk("rx_restart_done", RX_Done, 1);
        chk("rx_restart_err", Par_Err, 0);

        // start coincident with a data strobe: the strobe is discarded
        RX_Bit = 1'b1; RX_Bit_Strb = 1'b1;
        rx_start(3'b001, LW'(4));
        RX_Bit_Strb = 1'b0;
        rx_bit(0); rx_bit(0); rx_bit(0); rx_bit(0);
        rx_par(1'b0);
        @(negedge CLK);
        chk("rx_coinc_done", RX_Done, 1);
        chk("rx_coinc_err", Par_Err, 0);

        // saturation of the 2-bit counter
        Err_Clr = 1'b1;
        @(negedge CLK);
        Err_Clr = 1'b0;
        chk("clr_cnt", Err_Cnt, 0);
        chk("clr_sticky", Par_Err_Sticky, 0);
        for (int k = 1; k <= 5; k++) begin
            err_frame();
            @(negedge CLK);
            chk("sat_cnt", Err_Cnt, (k > 3) ? 3 : k);
        end

        // clear coincident with an error pulse wins
        rx_start(3'b011, LW'(5));
        for (int i = 0; i < 5; i++) rx_bit(1'b0);
        rx_par(1'b0);
        @(negedge CLK);
        chk("coclr_err", Par_Err, 1);
        Err_Clr = 1'b1;
        @(negedge CLK);
        Err_Clr = 1'b0;
        chk("coclr_cnt", Err_Cnt, 0);
        chk("coclr_sticky", Par_Err_Sticky, 0);

        // async reset mid-ACCUM with outputs non-zero
        err_frame();
        @(negedge CLK);
        tx_load(8'h00, 3'b011, LW'(8));
        @(negedge CLK);
        rx_start(3'b011, LW'(5));
        rx_bit(1); rx_bit(1);
        chk("pre_rst_sticky", Par_Err_Sticky, 1);
        chk("pre_rst_bit", TX_Par_Bit, 1);
        #1 RST = 1'b0;
        #1;
        chk("arst_tx_bit", TX_Par_Bit, 0);
        chk("arst_tx_en", TX_Par_En, 0);
        chk("arst_sticky", Par_Err_Sticky, 0);
        chk("arst_cnt", Err_Cnt, 0);
        chk("arst_done", RX_Done, 0);
        @(negedge CLK);
        RST = 1'b1;
        rx_bit(1); rx_bit(1); rx_bit(1);
        rx_par(1'b0);
        @(negedge CLK);
        chk("arst_idle_done", RX_Done, 0);
        chk("arst_idle_err", Par_Err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
